circuito_exp6_seq_game: RTL and testbench

//  Top-level sequence-memory game ("Genius"). Each round: player repeats stored moves 0..R, then enters one new move written at R+1.

---
 rtl/circuito_exp6_seq_game_if.sv | 37 +++
 rtl/circuito_exp6_seq_game.sv | 195 +++++++++++++++++++
 tb/tb_circuito_exp6_seq_game.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/circuito_exp6_seq_game_if.sv
// Signal bundle between the sequence-memory game and its environment.
// A play is the rising edge of |botoes; a game start is jogar held high in an idle or final state.
interface circuito_exp6_seq_game_if;
  logic       jogar;
  logic [3:0] botoes;
  logic [1:0] configuracao;
  logic       ganhou;
  logic       perdeu;
  logic       pronto;
  logic [3:0] leds;
  logic       timeout;
  logic       db_igual;
  logic [6:0] db_contagem;
  logic [6:0] db_memoria;
  logic [6:0] db_estado;
  logic [6:0] db_jogadafeita;
  logic       db_clock;
  logic       db_iniciar;
  logic       db_tem_jogada;
  logic       db_timeout;
  logic       db_fimRodada;
  logic       db_zeraCL;

  modport master (
    output jogar, botoes, configuracao,
    input  ganhou, perdeu, pronto, leds, timeout, db_igual, db_contagem, db_memoria,
           db_estado, db_jogadafeita, db_clock, db_iniciar, db_tem_jogada, db_timeout,
           db_fimRodada, db_zeraCL
  );

  modport slave (
    input  jogar, botoes, configuracao,
    output ganhou, perdeu, pronto, leds, timeout, db_igual, db_contagem, db_memoria,
           db_estado, db_jogadafeita, db_clock, db_iniciar, db_tem_jogada, db_timeout,
           db_fimRodada, db_zeraCL
  );
endinterface

// File: rtl/circuito_exp6_seq_game.sv
// Sequence-memory game: each round the player repeats the stored moves and then appends one.
// Control FSM plus memory, counters, play register, display/timeout timer and 7-seg debug.
module circuito_exp6_seq_game #(
  parameter int CLK_HZ   = 1000,
  parameter int SHOW_CYC = 2 * CLK_HZ,
  parameter int TOUT_CYC = 5 * CLK_HZ
) (
  input logic                     clock,
  input logic                     reset,
  circuito_exp6_seq_game_if.slave game
);

  typedef enum logic [3:0] {
    S_INICIAL       = 4'h0,
    S_PREPARACAO    = 4'h1,
    S_EXIBE         = 4'h2,
    S_ESPERA_JOGADA = 4'h3,
    S_REGISTRA      = 4'h4,
    S_COMPARA       = 4'h5,
    S_PROXIMA       = 4'h6,
    S_ESPERA_ADD    = 4'h7,
    S_REGISTRA_ADD  = 4'h8,
    S_GRAVA         = 4'h9,
    S_PROX_RODADA   = 4'hA,
    S_FINAL_ACERTO  = 4'hB,
    S_FINAL_ERRO    = 4'hE,
    S_FINAL_TIMEOUT = 4'hF
  } state_t;

  localparam int         TMAX = ((SHOW_CYC > TOUT_CYC) ? SHOW_CYC : TOUT_CYC) - 1;
  localparam int         TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
  localparam logic [3:0] MEM0 = 4'b0001;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      4'hF:    hex7 = 7'b0001110;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [3:0]    round_q, round_d;
  logic [1:0]    config_q, config_d;
  logic [3:0]    play_q;
  logic          any_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    mem_q [1:15];

  logic       tem_jogada;
  logic       igual;
  logic       waiting;
  logic       expired;
  logic       zera_cl;
  logic       mem_we;
  logic [3:0] mem_rd;
  logic [3:0] last_round;

  assign tem_jogada = (|game.botoes) & ~any_q;
  assign waiting    = (state_q == S_ESPERA_JOGADA) || (state_q == S_ESPERA_ADD);
  assign expired    = waiting && (timer_q >= TW'(TOUT_CYC - 1));
  assign igual      = (play_q == mem_rd);
  assign last_round = config_q[0] ? 4'd3 : 4'd15;

  // Entry 0 is the fixed first move; the rest are never read before grava has written them.
  always_comb begin
    mem_rd = MEM0;
    for (int i = 1; i < 16; i++) begin
      if (addr_q == 4'(i)) mem_rd = mem_q[i];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 1; i < 16; i++) begin
      if (mem_we && (round_q + 4'd1 == 4'(i))) mem_q[i] <= play_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    round_d  = round_q;
    config_d = config_q;
    zera_cl  = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      S_INICIAL:       if (game.jogar) state_d = S_PREPARACAO;
      S_PREPARACAO: begin
        addr_d   = 4'd0;
        round_d  = 4'd0;
        config_d = game.configuracao;
        zera_cl  = 1'b1;
        state_d  = S_EXIBE;
      end
      S_EXIBE:         if (timer_q == TW'(SHOW_CYC - 1)) state_d = S_ESPERA_JOGADA;
      S_ESPERA_JOGADA: begin
        if (tem_jogada)                   state_d = S_REGISTRA;
        else if (expired && config_q[1])  state_d = S_FINAL_TIMEOUT;
      end
      S_REGISTRA:      state_d = S_COMPARA;
      S_COMPARA: begin
        if (!igual)                       state_d = S_FINAL_ERRO;
        else if (addr_q < round_q)        state_d = S_PROXIMA;
        else if (round_q == last_round)   state_d = S_FINAL_ACERTO;
        else                              state_d = S_ESPERA_ADD;
      end
      S_PROXIMA: begin
        addr_d  = addr_q + 4'd1;
        state_d = S_ESPERA_JOGADA;
      end
      S_ESPERA_ADD: begin
        if (tem_jogada)                   state_d = S_REGISTRA_ADD;
        else if (expired && config_q[1])  state_d = S_FINAL_TIMEOUT;
      end
      S_REGISTRA_ADD:  state_d = S_GRAVA;
      S_GRAVA: begin
        mem_we  = 1'b1;
        state_d = S_PROX_RODADA;
      end
      S_PROX_RODADA: begin
        round_d = round_q + 4'd1;
        addr_d  = 4'd0;
        zera_cl = 1'b1;
        state_d = S_ESPERA_JOGADA;
      end
      S_FINAL_ACERTO, S_FINAL_ERRO, S_FINAL_TIMEOUT: begin
        if (game.jogar) state_d = S_PREPARACAO;
      end
      default:         state_d = S_INICIAL;
    endcase
  end

  // One timer serves the display phase and the idle timeout; any state change restarts it.
  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) || (waiting && tem_jogada)) begin
      timer_d = '0;
    end else if (((state_q == S_EXIBE) || waiting) && (timer_q != TW'(TMAX))) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_INICIAL;
      addr_q   <= 4'd0;
      round_q  <= 4'd0;
      config_q <= 2'b00;
      play_q   <= 4'd0;
      any_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      round_q  <= round_d;
      config_q <= config_d;
      any_q    <= |game.botoes;
      timer_q  <= timer_d;
      if (tem_jogada) play_q <= game.botoes;
    end
  end

  assign game.ganhou         = (state_q == S_FINAL_ACERTO);
  assign game.perdeu         = (state_q == S_FINAL_ERRO) || (state_q == S_FINAL_TIMEOUT);
  assign game.pronto         = game.ganhou || game.perdeu;
  assign game.timeout        = (state_q == S_FINAL_TIMEOUT);
  assign game.leds           = (state_q == S_EXIBE) ? MEM0 : game.botoes;
  assign game.db_igual       = igual;
  assign game.db_contagem    = hex7(addr_q);
  assign game.db_memoria     = hex7(mem_rd);
  assign game.db_estado      = hex7(state_q);
  assign game.db_jogadafeita = hex7(play_q);
  assign game.db_clock       = clock;
  assign game.db_iniciar     = game.jogar;
  assign game.db_tem_jogada  = tem_jogada;
  assign game.db_timeout     = expired;
  assign game.db_fimRodada   = (addr_q == round_q);
  assign game.db_zeraCL      = zera_cl;

endmodule

// File: tb/tb_circuito_exp6_seq_game.sv
// Bench for the sequence-memory game: directed scenarios plus randomized games scored
// against a move-sequence model of the rules.
module tb_circuito_exp6_seq_game;

  localparam int SHOW = 2000;
  localparam int TOUT = 5000;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  circuito_exp6_seq_game_if g ();

  circuito_exp6_seq_game dut (
    .clock (clock),
    .reset (reset),
    .game  (g.slave)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, expected game flow to complete");
    $fatal(1, "watchdog");
  end

  // Active-high segment table, inverted to the active-low display form.
  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] on;
    case (v)
      4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
      4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
      4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
      4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_ready(output logic [3:0] st);
    for (int c = 0; c < 3000; c++) begin
      if (g.db_estado == seg(4'h3)) begin st = 4'h3; return; end
      if (g.db_estado == seg(4'h7)) begin st = 4'h7; return; end
      if (g.db_estado == seg(4'hB)) begin st = 4'hB; return; end
      if (g.db_estado == seg(4'hE)) begin st = 4'hE; return; end
      if (g.db_estado == seg(4'hF)) begin st = 4'hF; return; end
      tick(1);
    end
    check("ready_wait_timeout", 32'd0, 32'd1);
    st = 4'h0;
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    g.botoes = b;
    #1;
    check("leds_echo", g.leds, b);
    tick(hold);
    g.botoes = 4'b0000;
    tick(5);
  endtask

  task automatic start_game(input logic [1:0] cfg);
    g.configuracao = cfg;
    g.jogar = 1'b1;
    tick(2);
    g.jogar = 1'b0;
    check("exibe_state", g.db_estado, seg(4'h2));
    check("exibe_leds", g.leds, 4'b0001);
    check("exibe_pronto", g.pronto, 1'b0);
  endtask

  function automatic logic [3:0] wrong_move(input logic [3:0] v);
    int s;
    logic [3:0] rot;
    s = $urandom_range(1, 3);
    rot = (v << s) | (v >> (4 - s));
    if ($urandom_range(0, 1) == 1) return v | rot;
    return rot;
  endfunction

  // Reference model: the game is a growing list of moves; round r replays moves 0..r then appends one.
  task automatic run_game(input logic [1:0] cfg, input int err_at, input int idle_first,
                          input int hold, input bit fixed_adds);
    logic [3:0] seq[$];
    logic [3:0] st, exp_st, mv;
    int  last, idx, kmax;
    bit  lost, abort;
    seq   = {4'b0001};
    last  = cfg[0] ? 3 : 15;
    idx   = 0;
    lost  = 1'b0;
    abort = 1'b0;
    start_game(cfg);
    for (int r = 0; r <= last && !lost && !abort; r++) begin
      kmax = (r == last) ? r : r + 1;
      for (int k = 0; k <= kmax && !lost && !abort; k++) begin
        wait_ready(st);
        exp_st = (k <= r) ? 4'h3 : 4'h7;
        check("wait_state", st, exp_st);
        if (st != exp_st) begin
          abort = 1'b1;
        end else begin
          check("address", g.db_contagem, seg(4'((k <= r) ? k : r)));
          if (idx == 0 && idle_first > 0) begin
            tick(idle_first);
            check("idle_state", g.db_estado, seg(4'h3));
            check("idle_perdeu", g.perdeu, 1'b0);
          end else begin
            tick($urandom_range(0, 12));
          end
          if (k <= r) begin
            mv = seq[k];
            if (idx == err_at) begin
              mv = wrong_move(seq[k]);
              lost = 1'b1;
            end
          end else begin
            mv = fixed_adds ? (4'b0010 << r) : (4'b0001 << $urandom_range(0, 3));
            seq.push_back(mv);
          end
          press(mv, hold);
          check("play_reg", g.db_jogadafeita, seg(mv));
          idx++;
        end
      end
    end
    if (!abort) begin
      check("end_state", g.db_estado, seg(lost ? 4'hE : 4'hB));
      check("ganhou", g.ganhou, !lost);
      check("perdeu", g.perdeu, lost);
      check("pronto", g.pronto, 1'b1);
      check("timeout", g.timeout, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] st;
    g.jogar = 1'b0;
    g.botoes = 4'b0000;
    g.configuracao = 2'b00;
    reset = 1'b1;
    tick(2);
    check("rst_state", g.db_estado, seg(4'h0));
    check("rst_ganhou", g.ganhou, 1'b0);
    check("rst_perdeu", g.perdeu, 1'b0);
    check("rst_pronto", g.pronto, 1'b0);
    check("rst_timeout", g.timeout, 1'b0);
    check("rst_leds", g.leds, 4'b0000);
    reset = 1'b0;
    tick(2);

    // demo win with adds 0010, 0100, 1000
    run_game(2'b01, -1, 0, 2, 1'b1);

    // wrong first move
    start_game(2'b01);
    wait_ready(st);
    check("t3_wait", st, 4'h3);
    press(4'b0010, 2);
    check("t3_state", g.db_estado, seg(4'hE));
    check("t3_perdeu", g.perdeu, 1'b1);
    check("t3_timeout", g.timeout, 1'b0);
    check("t3_pronto", g.pronto, 1'b1);

    // timeout enabled, no press: exact display length and timeout boundary
    start_game(2'b11);
    tick(SHOW - 1);
    check("t4_exibe_last", g.db_estado, seg(4'h2));
    tick(1);
    check("t4_espera", g.db_estado, seg(4'h3));
    tick(TOUT - 1);
    check("t4_before_tout", g.db_estado, seg(4'h3));
    check("t4_db_timeout", g.db_timeout, 1'b1);
    tick(1);
    check("t4_state", g.db_estado, seg(4'hF));
    check("t4_perdeu", g.perdeu, 1'b1);
    check("t4_timeout", g.timeout, 1'b1);
    check("t4_pronto", g.pronto, 1'b1);
    check("t4_ganhou", g.ganhou, 1'b0);

    // timeout disabled, long idle then a normal win
    run_game(2'b01, -1, 10000, 2, 1'b0);

    // reset mid round 2, then restart from round 0
    start_game(2'b01);
    wait_ready(st); press(4'b0001, 2);
    wait_ready(st); press(4'b0010, 2);
    wait_ready(st); press(4'b0001, 2);
    wait_ready(st); press(4'b0010, 2);
    wait_ready(st); press(4'b0100, 2);
    wait_ready(st); press(4'b0001, 2);
    check("t6_round2", g.db_estado, seg(4'h3));
    reset = 1'b1;
    #1;
    check("t6_async_rst", g.db_estado, seg(4'h0));
    tick(2);
    reset = 1'b0;
    tick(1);
    run_game(2'b01, -1, 0, 2, 1'b0);

    // buttons held long: one play per press
    run_game(2'b01, -1, 0, 25, 1'b0);

    // full 16-round game
    run_game(2'b00, -1, 0, 1, 1'b0);

    // randomized demo games, some with an injected wrong or multi-button move
    for (int i = 0; i < 6; i++) begin
      logic [1:0] cfg;
      int err;
      cfg = {1'($urandom_range(0, 1)), 1'b1};
      err = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 13)) : -1;
      run_game(cfg, err, 0, int'($urandom_range(1, 4)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
